// File: rtl/boss_beam_scheduler.sv
// Boss beam scheduler: paces beam shots across the four emitter lanes.
// A difficulty-selected cooldown spaces the shots. The preferred lane comes
// from the LFSR, and busy lanes are skipped round-robin. The number of
// concurrent beams is capped, and each shot is handshaked with its emitter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no boss on screen, nothing scheduled
// COOLDOWN | counting down the inter-shot delay, then waiting for a free slot
// SELECT   | probing lanes one per frame starting at the LFSR lane
// REQUEST  | fire_req held on the chosen lane until ack or timeout
// FIRED    | one-frame gap after an accepted shot
module boss_beam_scheduler #(
  parameter int CD_EASY     = 511,
  parameter int CD_MED      = 255,
  parameter int CD_HARD     = 63,
  parameter int MAX_HARD    = 2,
  parameter int ACK_TIMEOUT = 7
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       boss_exists,
  input  logic [2:0] difficulty,
  input  logic [1:0] LFSR_position,
  input  logic [3:0] lane_busy,
  input  logic [3:0] fire_ack,
  output logic [3:0] fire_req,
  output logic [1:0] fire_lane,
  output logic [2:0] active_count,
  output logic [2:0] sched_state,
  output logic [7:0] shot_count,
  output logic       ack_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COOLDOWN = 3'd1,
    ST_SELECT   = 3'd2,
    ST_REQUEST  = 3'd3,
    ST_FIRED    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] cd_q, cd_d, cd_load;
  logic [1:0] cand_q, cand_d;
  logic [1:0] probe_q, probe_d;
  logic [2:0] to_q, to_d;
  logic [3:0] req_d;
  logic [1:0] lane_d;
  logic [7:0] shot_d;
  logic       tmo_d;
  logic [2:0] cap;
  logic [2:0] busy_cnt;

  // Cooldown reload value and beam cap follow the current difficulty.
  always_comb begin
    case (difficulty)
      3'b100:  cd_load = 9'(CD_HARD);
      3'b010:  cd_load = 9'(CD_MED);
      default: cd_load = 9'(CD_EASY);
    endcase
    cap      = (difficulty == 3'b100) ? 3'(MAX_HARD) : 3'd1;
    busy_cnt = {2'b00, lane_busy[0]} + {2'b00, lane_busy[1]}
             + {2'b00, lane_busy[2]} + {2'b00, lane_busy[3]};
  end

  // Next-state and next-output logic. Losing the boss overrides every state.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    cand_d  = cand_q;
    probe_d = probe_q;
    to_d    = to_q;
    lane_d  = fire_lane;
    shot_d  = shot_count;
    tmo_d   = 1'b0;
    if (!boss_exists) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COOLDOWN;
          cd_d    = cd_load;
        end
        ST_COOLDOWN: begin
          if (cd_q != 9'd0) begin
            cd_d = cd_q - 9'd1;
          end else if (active_count < cap) begin
            state_d = ST_SELECT;
            cand_d  = LFSR_position;
            probe_d = 2'd0;
          end
        end
        ST_SELECT: begin
          if (!lane_busy[cand_q]) begin
            state_d = ST_REQUEST;
            lane_d  = cand_q;
            to_d    = 3'd0;
          end else begin
            cand_d = cand_q + 2'd1;
            if (probe_q == 2'd3) begin
              // Every lane was busy: re-check the cap on the next frame.
              state_d = ST_COOLDOWN;
              cd_d    = 9'd0;
            end else begin
              probe_d = probe_q + 2'd1;
            end
          end
        end
        ST_REQUEST: begin
          // An ack in the final frame still counts as a shot.
          if (fire_ack[fire_lane]) begin
            state_d = ST_FIRED;
            shot_d  = shot_count + 8'd1;
          end else if (to_q == 3'(ACK_TIMEOUT - 1)) begin
            state_d = ST_COOLDOWN;
            cd_d    = cd_load;
            tmo_d   = 1'b1;
          end else begin
            to_d = to_q + 3'd1;
          end
        end
        ST_FIRED: begin
          state_d = ST_COOLDOWN;
          cd_d    = cd_load;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    req_d = (state_d == ST_REQUEST) ? (4'b0001 << lane_d) : 4'b0000;
  end

  // FSM state register.
  always_ff @(posedge frame_clk) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Counters and registered outputs.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      cd_q         <= 9'(CD_EASY);
      cand_q       <= 2'd0;
      probe_q      <= 2'd0;
      to_q         <= 3'd0;
      fire_req     <= 4'b0000;
      fire_lane    <= 2'd0;
      shot_count   <= 8'd0;
      ack_timeout  <= 1'b0;
      active_count <= 3'd0;
    end else begin
      cd_q         <= cd_d;
      cand_q       <= cand_d;
      probe_q      <= probe_d;
      to_q         <= to_d;
      fire_req     <= req_d;
      fire_lane    <= lane_d;
      shot_count   <= shot_d;
      ack_timeout  <= tmo_d;
      active_count <= busy_cnt;
    end
  end

  assign sched_state = state_q;

endmodule

// File: tb/tb_boss_beam_scheduler.sv
// Testbench for boss_beam_scheduler: scenario-level reference model feeding
// a scoreboard of predicted output events (frame, fire_req, ack_timeout, shot_count).
module tb_boss_beam_scheduler;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       boss_exists;
  logic [2:0] difficulty;
  logic [1:0] LFSR_position;
  logic [3:0] lane_busy;
  logic [3:0] fire_ack;
  logic [3:0] fire_req;
  logic [1:0] fire_lane;
  logic [2:0] active_count;
  logic [2:0] sched_state;
  logic [7:0] shot_count;
  logic       ack_timeout;

  typedef struct {
    int         frame;
    logic [3:0] req;
    logic       tmo;
    logic [7:0] shot;
  } exp_t;

  exp_t exp_q[$];
  int   frame_no  = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   exp_shots = 0;

  logic [3:0] prev_req  = 4'b0;
  logic       prev_tmo  = 1'b0;
  logic [7:0] prev_shot = 8'd0;

  boss_beam_scheduler dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .boss_exists   (boss_exists),
    .difficulty    (difficulty),
    .LFSR_position (LFSR_position),
    .lane_busy     (lane_busy),
    .fire_ack      (fire_ack),
    .fire_req      (fire_req),
    .fire_lane     (fire_lane),
    .active_count  (active_count),
    .sched_state   (sched_state),
    .shot_count    (shot_count),
    .ack_timeout   (ack_timeout)
  );

  // Frame clock and frame counter.
  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) frame_no++;

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: run still going at frame %0d, required to have ended", frame_no);
    $fatal(1, "watchdog expired");
  end

  // Monitor: any change on the observed outputs must match the next predicted event.
  always @(negedge frame_clk) begin
    exp_t e;
    if (fire_req !== prev_req || ack_timeout !== prev_tmo || shot_count !== prev_shot) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: frame %0d req=%b tmo=%b shot=%0d, no event predicted",
                 frame_no, fire_req, ack_timeout, shot_count);
      end else begin
        e = exp_q.pop_front();
        if (frame_no != e.frame || fire_req !== e.req || ack_timeout !== e.tmo || shot_count !== e.shot) begin
          errors++;
          $display("FAIL event: got frame %0d req=%b tmo=%b shot=%0d, expected frame %0d req=%b tmo=%b shot=%0d",
                   frame_no, fire_req, ack_timeout, shot_count, e.frame, e.req, e.tmo, e.shot);
        end
      end
    end
    prev_req  = fire_req;
    prev_tmo  = ack_timeout;
    prev_shot = shot_count;
  end

  function automatic int cd_of(logic [2:0] d);
    case (d)
      3'b100:  return 63;
      3'b010:  return 255;
      default: return 511;
    endcase
  endfunction

  function automatic int cap_of(logic [2:0] d);
    return (d == 3'b100) ? 2 : 1;
  endfunction

  // Number of busy lanes skipped before a free one, or -1 if all are busy.
  function automatic int free_probe(logic [3:0] busy, logic [1:0] start);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (int'(start) + k) % 4;
      if (!busy[idx]) return k;
    end
    return -1;
  endfunction

  function automatic logic [2:0] rand_diff();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return 3'b100;
    if (r == 7) return 3'b010;
    if (r == 8) return 3'b001;
    return 3'($urandom);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (frame %0d)", name, act, expv, frame_no);
    end
  endtask

  task automatic wait_to(input int n);
    while (frame_no < n) @(negedge frame_clk);
  endtask

  task automatic push(input int f, input logic [3:0] r, input logic t, input int s);
    exp_t e;
    e.frame = f;
    e.req   = r;
    e.tmo   = t;
    e.shot  = 8'(s);
    exp_q.push_back(e);
  endtask

  // One shot scenario started from IDLE.
  // mode: 0 ack at REQUEST frame j, 1 no ack, 2 boss lost at j, 3 reset at j, 4 no ack then refire.
  task automatic run_tx(input logic [2:0] d1, input logic [2:0] d2, input logic [1:0] lfsr,
                        input logic [3:0] ba, input logic [3:0] bb, input int mode, input int j);
    int B, cd, cap, k, P, Q, lane_i;
    logic [3:0] oh, noise;
    @(negedge frame_clk);
    boss_exists   = 1'b0;
    fire_ack      = 4'b0;
    difficulty    = d1;
    LFSR_position = lfsr;
    lane_busy     = ba;
    @(negedge frame_clk);
    @(negedge frame_clk);
    chk("active_count", int'(active_count), $countones(ba));
    chk("idle_state", int'(sched_state), 0);
    B = frame_no + 1;
    boss_exists = 1'b1;
    cd  = cd_of(d1);
    cap = cap_of(d2);
    wait_to(B + 1);
    difficulty = d2;
    if ($countones(ba) >= cap) begin
      wait_to(B + cd + 8);
      chk("cap_hold_state", int'(sched_state), 1);
      chk("cap_hold_req", int'(fire_req), 0);
      return;
    end
    wait_to(B + cd + 1);
    lane_busy = bb;
    k = free_probe(bb, lfsr);
    if (k < 0) begin
      wait_to(B + cd + 12);
      chk("all_busy_state", int'(sched_state), 1);
      chk("all_busy_req", int'(fire_req), 0);
      return;
    end
    lane_i = (int'(lfsr) + k) % 4;
    oh     = 4'b0001 << lane_i;
    P      = B + cd + 2 + k;
    push(P, oh, 1'b0, exp_shots);
    noise = 4'($urandom) & ~oh;
    wait_to(P - 1);
    chk("select_state", int'(sched_state), 2);
    wait_to(P);
    chk("request_state", int'(sched_state), 3);
    chk("fire_lane", int'(fire_lane), lane_i);
    fire_ack = noise;
    case (mode)
      0: begin
        push(P + j, 4'b0, 1'b0, exp_shots + 1);
        exp_shots++;
        wait_to(P + j - 1);
        fire_ack = noise | oh;
        wait_to(P + j);
        fire_ack = 4'b0;
      end
      1, 4: begin
        push(P + 7, 4'b0, 1'b1, exp_shots);
        push(P + 8, 4'b0, 1'b0, exp_shots);
        wait_to(P + 8);
        fire_ack = 4'b0;
        if (mode == 4) begin
          Q = P + 7 + cd_of(d2) + 2 + k;
          push(Q, oh, 1'b0, exp_shots);
          push(Q + 1, 4'b0, 1'b0, exp_shots);
          wait_to(Q);
          boss_exists = 1'b0;
        end
      end
      2: begin
        push(P + j, 4'b0, 1'b0, exp_shots);
        wait_to(P + j - 1);
        boss_exists = 1'b0;
        wait_to(P + j);
        chk("boss_lost_state", int'(sched_state), 0);
        fire_ack = 4'b0;
      end
      default: begin
        push(P + j, 4'b0, 1'b0, 0);
        exp_shots = 0;
        wait_to(P + j - 1);
        Reset = 1'b0;
        wait_to(P + j);
        chk("reset_req_state", int'(sched_state), 0);
        chk("reset_req_lane", int'(fire_lane), 0);
        Reset    = 1'b1;
        fire_ack = 4'b0;
      end
    endcase
  endtask

  // Stimulus.
  initial begin
    logic [2:0] d1, d2;
    logic [3:0] ba, bb;
    int r, mode, j;
    Reset         = 1'b0;
    boss_exists   = 1'b0;
    difficulty    = 3'b100;
    LFSR_position = 2'd0;
    lane_busy     = 4'b0;
    fire_ack      = 4'b0;
    @(negedge frame_clk);
    @(negedge frame_clk);
    chk("reset_state", int'(sched_state), 0);
    chk("reset_fire_req", int'(fire_req), 0);
    chk("reset_fire_lane", int'(fire_lane), 0);
    chk("reset_active_count", int'(active_count), 0);
    chk("reset_shot_count", int'(shot_count), 0);
    chk("reset_ack_timeout", int'(ack_timeout), 0);
    Reset = 1'b1;

    run_tx(3'b100, 3'b100, 2'd0, 4'b0000, 4'b0000, 0, 3);
    run_tx(3'b001, 3'b001, 2'd2, 4'b0000, 4'b0100, 0, 2);
    run_tx(3'b100, 3'b100, 2'd1, 4'b1111, 4'b1111, 0, 1);
    run_tx(3'b010, 3'b010, 2'd3, 4'b0000, 4'b0000, 4, 1);
    run_tx(3'b100, 3'b100, 2'd1, 4'b0000, 4'b0000, 2, 3);
    run_tx(3'b100, 3'b100, 2'd2, 4'b0100, 4'b0110, 3, 4);

    repeat (100) begin
      d1 = rand_diff();
      d2 = ($urandom_range(0, 4) == 0) ? rand_diff() : d1;
      if ($urandom_range(0, 4) == 0)
        ba = 4'($urandom);
      else if (cap_of(d2) == 2 && $urandom_range(0, 1) == 1)
        ba = 4'b0001 << $urandom_range(0, 3);
      else
        ba = 4'b0000;
      bb = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom);
      r  = $urandom_range(0, 9);
      j  = $urandom_range(1, 7);
      if (r <= 5)      mode = 0;
      else if (r <= 7) mode = 1;
      else if (r == 8) mode = 2;
      else begin
        mode = 0;
        j    = 7;
      end
      run_tx(d1, d2, 2'($urandom), ba, bb, mode, j);
    end

    while (exp_shots < 260) begin
      j = ($urandom_range(0, 3) == 0) ? 7 : $urandom_range(1, 7);
      run_tx(3'b100, 3'b100, 2'($urandom), 4'b0000, 4'($urandom), 0, j);
    end
    chk("shot_wrap", int'(shot_count), exp_shots % 256);

    @(negedge frame_clk);
    boss_exists = 1'b0;
    repeat (5) @(negedge frame_clk);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
